// File: rtl/operand_fetch_pkg.sv
// ---------------------------------------------------------------------------
// operand_fetch_pkg
// Shared definitions for the operand fetch unit:
//   - of_state_e   : FSM state encoding (IDLE, RD_RS1, RD_RS2, DONE)
//   - RS1_LSB/RS2_LSB : source register field positions in the instruction
//   - NUM_REGS     : architectural register count (RV32E, 16 registers)
//   - idx_illegal  : flags a 5-bit register index outside the RV32E file
// ---------------------------------------------------------------------------
package operand_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RD_RS1 = 2'd1,
      ST_RD_RS2 = 2'd2,
      ST_DONE   = 2'd3
   } of_state_e;

   localparam int RS1_LSB    = 15;
   localparam int RS2_LSB    = 20;
   localparam int NUM_REGS   = 16;
   localparam int REG_IDX_W  = 5;                 // index width in the encoding
   localparam int REG_ADDR_W = $clog2(NUM_REGS);  // address width of the file

   // With 16 registers any index carrying the top encoding bit is out of range.
   function automatic logic idx_illegal(input logic [REG_IDX_W-1:0] idx);
      return idx[REG_ADDR_W];
   endfunction

endpackage

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
// Reads the two source operands of an instruction from an external,
// combinational register file, one per cycle, and presents them together
// with a one-cycle done pulse.
//
// Optional feature: define OPERAND_FETCH_BYPASS_EN to forward same-cycle
// register-file write data (wb_*) into the operand being captured. Without
// it the capture always sees rf_data (the pre-write value) and the wb_*
// inputs are present but unused.
//
// Handshake: start is a request sampled only while ready=1 (IDLE); when
// sampled high the instruction is latched and the fetch proceeds with fixed
// latency. start in any other state is dropped. done pulses for one cycle
// when op_a/op_b/illegal are valid; those outputs then hold until the next
// capture.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, instr    fetch request and instruction word (rs1=[19:15], rs2=[24:20])
//   ready           high in IDLE (and while rst is asserted)
//   read_reg        register-file read address (0 in IDLE/DONE)
//   rf_data         register-file read data for read_reg
//   wb_en/reg/data  register-file write port of the current cycle
//   op_a, op_b      captured rs1 / rs2 values
//   done            one-cycle valid pulse
//   illegal         an index was >= 16; valid with done
//   dbg_state_o     current FSM state, for observation
// ---------------------------------------------------------------------------
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int BIT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [31:0]          instr,
   output logic                 ready,
   output logic [3:0]           read_reg,
   input  logic [BIT_WIDTH-1:0] rf_data,
   input  logic                 wb_en,
   input  logic [3:0]           wb_reg,
   input  logic [BIT_WIDTH-1:0] wb_data,
   output logic [BIT_WIDTH-1:0] op_a,
   output logic [BIT_WIDTH-1:0] op_b,
   output logic                 done,
   output logic                 illegal,
   output logic [1:0]           dbg_state_o
);

   of_state_e              state_q, state_d;
   logic [31:0]            instr_q, instr_d;
   logic [BIT_WIDTH-1:0]   op_a_q, op_a_d;
   logic [BIT_WIDTH-1:0]   op_b_q, op_b_d;
   logic                   illegal_q, illegal_d;

   logic                   ready_c;
   logic                   done_c;
   logic [REG_ADDR_W-1:0]  read_reg_c;

   logic [REG_IDX_W-1:0]   rs1_idx;
   logic [REG_IDX_W-1:0]   rs2_idx;
   logic                   hit_rs1;
   logic                   hit_rs2;

   assign rs1_idx = instr_q[RS1_LSB +: REG_IDX_W];
   assign rs2_idx = instr_q[RS2_LSB +: REG_IDX_W];

   // Register 0 and out-of-range indices read as zero before any forwarding.
   function automatic logic [BIT_WIDTH-1:0] select_operand(
      input logic [REG_IDX_W-1:0] idx,
      input logic [BIT_WIDTH-1:0] rf_val,
      input logic                 fwd_hit,
      input logic [BIT_WIDTH-1:0] fwd_val
   );
      logic [BIT_WIDTH-1:0] res;
      if ((idx == '0) || idx_illegal(idx)) begin
         res = '0;
      end else if (fwd_hit) begin
         res = fwd_val;
      end else begin
         res = rf_val;
      end
      return res;
   endfunction

`ifdef OPERAND_FETCH_BYPASS_EN
   assign hit_rs1 = wb_en && (wb_reg == rs1_idx[REG_ADDR_W-1:0]);
   assign hit_rs2 = wb_en && (wb_reg == rs2_idx[REG_ADDR_W-1:0]);
`else
   logic unused_wb;
   assign hit_rs1   = 1'b0;
   assign hit_rs2   = 1'b0;
   assign unused_wb = ^{wb_en, wb_reg};
`endif

   // Only the register fields of the latched instruction are consumed.
   logic unused_instr;
   assign unused_instr = ^{instr_q[31:25], instr_q[14:0]};

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      illegal_d  = illegal_q;
      ready_c    = 1'b0;
      done_c     = 1'b0;
      read_reg_c = '0;

      case (state_q)
         ST_IDLE: begin
            ready_c = 1'b1;
            if (start) begin
               instr_d   = instr;
               illegal_d = 1'b0;   // sticky flag restarts with each fetch
               state_d   = ST_RD_RS1;
            end
         end
         ST_RD_RS1: begin
            read_reg_c = rs1_idx[REG_ADDR_W-1:0];
            op_a_d     = select_operand(rs1_idx, rf_data, hit_rs1, wb_data);
            if (idx_illegal(rs1_idx)) begin
               illegal_d = 1'b1;
            end
            state_d = ST_RD_RS2;
         end
         ST_RD_RS2: begin
            read_reg_c = rs2_idx[REG_ADDR_W-1:0];
            op_b_d     = select_operand(rs2_idx, rf_data, hit_rs2, wb_data);
            if (idx_illegal(rs2_idx)) begin
               illegal_d = 1'b1;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         illegal_q <= illegal_d;
      end
   end

   // While rst is held the handshake outputs look idle even if the state
   // register has not yet been cleared by the reset edge.
   assign ready       = ready_c | rst;
   assign done        = done_c & ~rst;
   assign read_reg    = rst ? '0 : read_reg_c;
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign illegal     = illegal_q;
   assign dbg_state_o = state_q;

endmodule
